// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared burst geometry and control state type for the Mono8 parallelizer
package pixel_stream_pkg;
  localparam int PIXELS_PER_BURST = 32;
  localparam int PIX_W = 8;
  localparam int BURST_W = 256;
  localparam int IDX_W = $clog2(PIXELS_PER_BURST);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_e;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: byte-lane accumulator that merges the incoming pixel into the assembled word
module word_assembler
  import pixel_stream_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_i,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            idx_i,
  input  logic [PIX_W-1:0]            pix_i,
  output logic [BURST_W-1:0]          word_o,
  output logic [PIXELS_PER_BURST-1:0] keep_o
);
  logic [BURST_W-1:0] acc_q, acc_d;
  // the current pixel is merged combinationally so a completing beat loads the full word
  always_comb begin
    word_o = acc_q;
    if (we_i) word_o[{idx_i, 3'b000} +: PIX_W] = pix_i;
    acc_d = clear_i ? '0 : word_o;
    keep_o = '0;
    for (int k = 0; k < PIXELS_PER_BURST; k++) keep_o[k] = IDX_W'(k) <= idx_i;
  end
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/parallelizer_mono8.sv
// parallelizer_mono8: packs Mono8 pixels into 256-bit AXI-Stream words; PARALLELIZER_TUSER_EN adds m_axis_tuser
module parallelizer_mono8
  import pixel_stream_pkg::*;
#(
  parameter int OUT_ROWS = 20,
  parameter int OUT_COLS = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  output logic                          ap_ready,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [PIX_W-1:0]              s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [BURST_W-1:0]            m_axis_tdata,
  output logic [PIXELS_PER_BURST-1:0]   m_axis_tkeep,
  output logic                          m_axis_tlast,
`ifdef PARALLELIZER_TUSER_EN
  output logic                          m_axis_tuser,
`endif
  output logic [$clog2(OUT_COLS)-1:0]   cnt_col,
  output logic [$clog2(OUT_ROWS)-1:0]   cnt_row
);
  localparam int CW = $clog2(OUT_COLS);
  localparam int RW = $clog2(OUT_ROWS);
  state_e state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [IDX_W-1:0] idx_q;
  logic tvalid_q, tlast_q;
  logic [BURST_W-1:0] tdata_q, word;
  logic [PIXELS_PER_BURST-1:0] tkeep_q, keep;
  logic last_col, last_pix, word_done, hs, start, load;
  assign last_col = col_q == CW'(OUT_COLS - 1);
  assign last_pix = last_col && row_q == RW'(OUT_ROWS - 1);
  assign word_done = idx_q == IDX_W'(PIXELS_PER_BURST - 1) || last_pix;
  // stall only the pixel that would need the output register while it is still occupied
  assign s_axis_tready = state_q == ACTIVE && !(s_axis_tvalid && word_done && tvalid_q && !m_axis_tready);
  assign hs = s_axis_tvalid && s_axis_tready;
  assign start = state_q == IDLE && ap_start;
  assign load = hs && word_done;
  word_assembler u_asm (
    .clk(clk), .reset(reset), .clear_i(start || load), .we_i(hs),
    .idx_i(idx_q), .pix_i(s_axis_tdata), .word_o(word), .keep_o(keep)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ap_start ? ACTIVE : IDLE;
      ACTIVE:  state_d = hs && last_pix ? DRAIN : ACTIVE;
      DRAIN:   state_d = tvalid_q && m_axis_tready && tlast_q ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || start) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else if (hs) begin
      col_q <= last_col ? '0 : col_q + 1'b1;
      row_q <= last_pix ? '0 : last_col ? row_q + 1'b1 : row_q;
      idx_q <= word_done ? '0 : idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tdata_q <= word;
      tkeep_q <= keep;
      tlast_q <= last_pix;
    end else if (m_axis_tready) tvalid_q <= 1'b0;
  end
`ifdef PARALLELIZER_TUSER_EN
  logic first_q, tuser_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= 1'b0;
      tuser_q <= 1'b0;
    end else begin
      first_q <= start ? 1'b1 : load ? 1'b0 : first_q;
      tuser_q <= load ? first_q : tuser_q;
    end
  end
  assign m_axis_tuser = tuser_q;
`endif
  assign ap_idle = state_q == IDLE;
  assign ap_ready = state_q == IDLE;
  assign ap_done = state_q == DONE;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata = tdata_q;
  assign m_axis_tkeep = tkeep_q;
  assign m_axis_tlast = tlast_q;
  assign cnt_col = col_q;
  assign cnt_row = row_q;
endmodule

// File: tb/tb_parallelizer_mono8.sv
// tb_parallelizer_mono8: directed table-driven bench over 4x8, 5x7 and 8x8 frame instances
module tb_parallelizer_mono8;
  logic clk = 0, reset = 1, m_tready = 1;
  logic [7:0] s_tdata = 0;
  logic [2:0] ap_start = 0, s_tvalid = 0;
  logic [2:0] s_tready, ap_ready, ap_idle, ap_done, tv, tl, tu;
  logic [255:0] td [3];
  logic [31:0] tk [3];
  logic [2:0] col0, col1, col2, row1, row2;
  logic [1:0] row0;
  int total = 0, bad = 0;

  typedef struct {int dut; int base; logic [31:0] keep; logic last; logic user;} exp_t;
  typedef struct {int dut; logic [255:0] data; logic [31:0] keep; logic last; logic user;} cap_t;
  exp_t ex [6];
  cap_t got [$];

  always #5 clk = ~clk;

  parallelizer_mono8 #(.OUT_ROWS(4), .OUT_COLS(8)) d0 (
    .clk(clk), .reset(reset), .ap_start(ap_start[0]), .ap_ready(ap_ready[0]), .ap_idle(ap_idle[0]),
    .ap_done(ap_done[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(tv[0]), .m_axis_tready(m_tready), .m_axis_tdata(td[0]), .m_axis_tkeep(tk[0]),
    .m_axis_tlast(tl[0]),
`ifdef PARALLELIZER_TUSER_EN
    .m_axis_tuser(tu[0]),
`endif
    .cnt_col(col0), .cnt_row(row0));
  parallelizer_mono8 #(.OUT_ROWS(5), .OUT_COLS(7)) d1 (
    .clk(clk), .reset(reset), .ap_start(ap_start[1]), .ap_ready(ap_ready[1]), .ap_idle(ap_idle[1]),
    .ap_done(ap_done[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(tv[1]), .m_axis_tready(m_tready), .m_axis_tdata(td[1]), .m_axis_tkeep(tk[1]),
    .m_axis_tlast(tl[1]),
`ifdef PARALLELIZER_TUSER_EN
    .m_axis_tuser(tu[1]),
`endif
    .cnt_col(col1), .cnt_row(row1));
  parallelizer_mono8 #(.OUT_ROWS(8), .OUT_COLS(8)) d2 (
    .clk(clk), .reset(reset), .ap_start(ap_start[2]), .ap_ready(ap_ready[2]), .ap_idle(ap_idle[2]),
    .ap_done(ap_done[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(tv[2]), .m_axis_tready(m_tready), .m_axis_tdata(td[2]), .m_axis_tkeep(tk[2]),
    .m_axis_tlast(tl[2]),
`ifdef PARALLELIZER_TUSER_EN
    .m_axis_tuser(tu[2]),
`endif
    .cnt_col(col2), .cnt_row(row2));
`ifndef PARALLELIZER_TUSER_EN
  assign tu = '0;
`endif

  // beats are recorded half a cycle before the edge that completes them
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (tv[i] && m_tready) got.push_back('{i, td[i], tk[i], tl[i], tu[i]});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] cnt_of(input int sel);
    return sel == 0 ? {1'b0, row0, col0} : sel == 1 ? {row1, col1} : {row2, col2};
  endfunction

  function automatic logic [255:0] exp_word(input int base, input logic [31:0] keep);
    logic [255:0] w = '0;
    for (int k = 0; k < 32; k++) if (keep[k]) w[8*k +: 8] = 8'(base + k);
    return w;
  endfunction

  task automatic send_frame(input int sel, input int n, input int off, input int cols);
    int w;
    @(posedge clk) #1;
    ap_start[sel] = 1;
    @(posedge clk) #1;
    ap_start[sel] = 0;
    for (int p = 0; p < n; p++) begin
      s_tdata = 8'(p + off);
      s_tvalid[sel] = 1;
      w = 0;
      @(negedge clk);
      chk($sformatf("cnt d%0d p%0d", sel, p), cnt_of(sel), {3'(p / cols), 3'(p % cols)});
      while (!s_tready[sel] && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (w >= 200) chk("tready timeout", 0, 1);
      @(posedge clk) #1;
    end
    s_tvalid[sel] = 0;
  endtask

  task automatic wait_done(input int sel);
    int w = 0;
    @(negedge clk);
    while (!ap_done[sel] && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk($sformatf("ap_done pulse d%0d", sel), ap_done[sel], 1);
    @(negedge clk);
    chk("ap_done one cycle", ap_done[sel], 0);
    chk("idle after done", ap_idle[sel], 1);
    chk("cnt after done", cnt_of(sel), 0);
  endtask

  initial begin
    ex[0] = '{0, 0, 32'hFFFF_FFFF, 1'b1, 1'b1};
    ex[1] = '{1, 0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    ex[2] = '{1, 32, 32'h0000_0007, 1'b1, 1'b0};
    ex[3] = '{2, 0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    ex[4] = '{2, 32, 32'hFFFF_FFFF, 1'b1, 1'b0};
    ex[5] = '{0, 64, 32'hFFFF_FFFF, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst ap_idle", ap_idle[0], 1);
    chk("rst ap_ready", ap_ready[0], 1);
    chk("rst ap_done", ap_done[0], 0);
    chk("rst s_tready", s_tready[0], 0);
    chk("rst tvalid", tv[0], 0);
    chk("rst tdata", td[0], 0);
    chk("rst tkeep", tk[0], 0);
    chk("rst tlast", tl[0], 0);
    chk("rst cnt", cnt_of(0), 0);
    send_frame(0, 32, 0, 8);
    wait_done(0);
    send_frame(1, 35, 0, 7);
    wait_done(1);
    @(posedge clk) #1;
    m_tready = 0;
    fork
      send_frame(2, 64, 0, 8);
      begin
        int w = 0;
        @(negedge clk);
        while (!tv[2] && w < 300) begin
          w++;
          @(negedge clk);
        end
        chk("first word valid", tv[2], 1);
        repeat (35) @(negedge clk);
        chk("stall s_tready", s_tready[2], 0);
        chk("stall cnt", cnt_of(2), 6'o77);
        chk("stall tdata held", td[2], exp_word(0, 32'hFFFF_FFFF));
        repeat (5) @(negedge clk);
        @(posedge clk) #1;
        m_tready = 1;
      end
    join
    wait_done(2);
    send_frame(0, 18, 0, 8);
    @(posedge clk) #1;
    reset = 1;
    @(posedge clk) #1;
    reset = 0;
    @(negedge clk);
    chk("mid rst tvalid", tv[0], 0);
    chk("mid rst idle", ap_idle[0], 1);
    chk("mid rst cnt", cnt_of(0), 0);
    send_frame(0, 32, 64, 8);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("beat count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk($sformatf("beat%0d dut", i), got[i].dut, ex[i].dut);
      chk($sformatf("beat%0d tdata", i), got[i].data, exp_word(ex[i].base, ex[i].keep));
      chk($sformatf("beat%0d tkeep", i), got[i].keep, ex[i].keep);
      chk($sformatf("beat%0d tlast", i), got[i].last, ex[i].last);
`ifdef PARALLELIZER_TUSER_EN
      chk($sformatf("beat%0d tuser", i), got[i].user, ex[i].user);
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parallelizer_mono8.md
PARALLELIZER_MONO8 -- requirements
Module: parallelizer_mono8

Interface
REQ-001 SHALL have parameter OUT_ROWS, default 20, meaning frame height in pixels.
REQ-002 SHALL have parameter OUT_COLS, default 20, meaning frame width in pixels.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port ap_start, input, 1, request to accept one frame.
REQ-006 SHALL have ports ap_ready, ap_idle and ap_done, output, 1 each, block control status.
REQ-007 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1) and s_axis_tdata (input, 8): one Mono8 pixel per beat.
REQ-008 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, 256), m_axis_tkeep (output, 32) and m_axis_tlast (output, 1).
REQ-009 SHALL have ports cnt_col (output, $clog2(OUT_COLS)) and cnt_row (output, $clog2(OUT_ROWS)): coordinates of the next pixel to be accepted.

Function
REQ-010 SHALL pack 32 consecutive input pixels into one 256-bit word, with the first pixel in bits [7:0] and pixel k in bits [8k+7:8k].
REQ-011 SHALL implement states IDLE, ACTIVE, DRAIN and DONE.
REQ-012 IDLE: ap_idle=1, ap_ready=1, s_axis_tready=0; on ap_start=1, clear all counters and go to ACTIVE.
REQ-013 ACTIVE: s_axis_tready=1 unless a word-completing pixel is offered while the output register is full and m_axis_tready=0.
- A word-completing pixel is burst index 31 or the last frame pixel.
REQ-014 On a word-completing handshake, the assembled word SHALL load the output register with m_axis_tvalid=1 in the next cycle (latency 1); sustained throughput SHALL be 1 pixel/cycle with no bubble.
REQ-015 m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 m_axis_tkeep SHALL have bit k set iff byte k carries a frame pixel; unused bytes of a partial final word SHALL be zero.
REQ-017 m_axis_tlast SHALL be 1 only on the word containing pixel OUT_ROWS*OUT_COLS-1.
REQ-018 cnt_col SHALL increment on each input handshake, wrapping at OUT_COLS-1; cnt_row SHALL increment on that wrap.
REQ-019 After the last frame pixel is accepted, SHALL go to DRAIN with s_axis_tready=0; on the tlast output handshake, SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with ap_done=1, then return to IDLE with counters at 0.
REQ-021 ap_start outside IDLE SHALL be ignored.

Reset
REQ-022 reset SHALL force IDLE, clear all counters and the accumulator, and clear m_axis_tvalid, tlast, tkeep, tdata and ap_done to 0.
REQ-023 reset mid-frame SHALL discard partial and pending words, with no output beat in the following cycle.

Configuration
REQ-024 With PARALLELIZER_TUSER_EN defined, SHALL add output m_axis_tuser (1 bit), set to 1 only on the first word of a frame and held like tdata.
REQ-025 Without PARALLELIZER_TUSER_EN, the port and its logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-026 Shared package pixel_stream_pkg SHALL hold PIXELS_PER_BURST=32, PIX_W=8, BURST_W=256 and the state enum type.
REQ-027 Sub-module word_assembler SHALL implement byte-lane accumulation (write-enable, byte index, clear) and SHALL produce the assembled word.

Verification
REQ-028 4x8 frame, pixel n=n, no backpressure -> one beat, tdata bytes 0..31 = 0x00..0x1F, tkeep=0xFFFFFFFF, tlast=1, then ap_done pulse.
REQ-029 5x7 frame -> two beats; second beat: bytes 0..2 = 0x20..0x22, remaining bytes 0, tkeep=0x00000007, tlast=1 only on the second beat.
REQ-030 8x8 frame, m_axis_tready low for 40 cycles after the first word -> s_axis_tready=0 while the 64th pixel is offered; both words arrive intact in order.
REQ-031 reset asserted after pixel 17 of 4x8 -> no output beat; a new ap_start with a fresh frame yields a correct single word.
REQ-032 cnt_row/cnt_col on a 5x7 frame -> (0,0)..(0,6),(1,0)...; after DONE -> (0,0). With PARALLELIZER_TUSER_EN defined, tuser=1 on the first beat only.
